register_read_stage: RTL and testbench
======================================

REGISTER_READ_STAGE -- requirements
Module: register_read_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port RegWriteWB, input, 1 bit: write-back write enable.
REQ-004 The block SHALL have port WriteRegWB, input, 5 bits: write-back destination register.
REQ-005 The block SHALL have port FinalWriteData, input, 64 bits: write-back data (writeBack mux output).
REQ-006 The block SHALL have port in_valid, input, 1 bit: decoded instruction present this cycle.
REQ-007 The block SHALL have ports Rn, Rm and Rd, input, 5 bits each: source and destination register numbers.
REQ-008 The block SHALL have port MemReadID, input, 1 bit: the decoded instruction is a load.
REQ-009 The block SHALL have port CtrlID, input, CTRL_W=16 bits: opaque control bundle passed to EX.
REQ-010 The block SHALL have port flush, input, 1 bit: taken branch; squash the ID instruction.
REQ-011 The block SHALL have ports ReadData1EX and ReadData2EX, output, 64 bits each: registered operands.
REQ-012 The block SHALL have ports RnEX, RmEX and RdEX, output, 5 bits each: registered register numbers.
REQ-013 The block SHALL have port MemReadEX, output, 1 bit: registered load flag.
REQ-014 The block SHALL have port CtrlEX, output, 16 bits: registered control bundle.
REQ-015 The block SHALL have port ValidEX, output, 1 bit: EX slot holds a real instruction.
REQ-016 The block SHALL have port stall, output, 1 bit, combinational: hold PC and IF/ID this cycle.

Function
REQ-017 The block SHALL hold a 32x64 register file; X31 SHALL read as 0, and writes to X31 SHALL be ignored.
REQ-018 The block SHALL write the register file on the rising clk edge when RegWriteWB=1 and WriteRegWB!=31.
REQ-019 Register-file reads SHALL be combinational, giving 1 cycle of latency from Rn/Rm to ReadData1EX/ReadData2EX.
REQ-020 When RegWriteWB=1 and WriteRegWB==Rn!=31, the Rn read SHALL return FinalWriteData, the same-cycle write bypass; Rm SHALL behave identically.
REQ-021 load_use SHALL be ValidEX & MemReadEX & RdEX!=31 & in_valid & (RdEX==Rn | RdEX==Rm).
REQ-022 stall SHALL be load_use & !flush.
REQ-023 On flush, the ID/EX register SHALL load a bubble.
REQ-024 When stall=1 and flush=0, the ID/EX register SHALL load a bubble, and the upstream stage SHALL re-present the same instruction next cycle.
REQ-025 Otherwise, the ID/EX register SHALL load the read data, Rn, Rm, Rd, MemReadID, CtrlID and ValidEX=in_valid.
REQ-026 A bubble SHALL be ValidEX=0, MemReadEX=0, CtrlEX=0 and RdEX=31, while the data and register-number fields still update.
REQ-027 A stalled instruction re-presented next cycle SHALL see no load-use against the bubble and SHALL proceed.
REQ-028 When in_valid=0, the block SHALL never assert stall.
REQ-029 A write-back and a flush in the same cycle SHALL both take effect; the write is never dropped.

Reset
REQ-030 When reset_n=0, the block SHALL asynchronously clear all 32 registers to 0.
REQ-031 When reset_n=0, the ID/EX register SHALL asynchronously load a bubble with ReadData1EX=ReadData2EX=0 and RnEX=RmEX=31.
REQ-032 Reset SHALL override any in-progress stall; on reset release, stall SHALL be 0.
REQ-033 Registers SHALL update on the first rising edge after reset_n deasserts.

Structure
REQ-034 Package cpu_pkg SHALL hold XLEN=64, NUM_REGS=32, ZERO_REG=5'd31, CTRL_W=16 and the idex_t struct covering the ID/EX fields.
REQ-035 Sub-module regfile SHALL implement the array, X31 zero and write logic, and SHALL provide two combinational read ports.
REQ-036 Bypass, hazard detection and the ID/EX register SHALL reside in register_read_stage.

Verification
REQ-037 Bench SHALL cover: write X5=64'd155 via RegWriteWB; next cycle Rn=5 -> ReadData1EX=155 one edge later.
REQ-038 Bench SHALL cover: same cycle RegWriteWB=1, WriteRegWB=7, FinalWriteData=99, Rm=7 -> ReadData2EX=99 after that edge (bypass).
REQ-039 Bench SHALL cover: write X31=12, then read Rn=31 -> ReadData1EX=0.
REQ-040 Bench SHALL cover: load (MemReadID=1, Rd=3) followed by Rn=3 -> stall=1 for exactly one cycle, one bubble (ValidEX=0), then the dependent instruction issues.
REQ-041 Bench SHALL cover: flush=1 during a load-use condition -> stall=0, bubble loaded, write-back still committed.
REQ-042 Bench SHALL cover: reset_n pulsed low mid-stall, asynchronously between edges -> all outputs bubble/zero immediately, and all registers read 0 afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and the ID/EX pipeline record
//
// Purpose: common definitions for the register-read (ID) stage.
// Contents:
//   XLEN, NUM_REGS, ZERO_REG, CTRL_W - datapath and register-file sizes
//   idex_t      - fields latched in the ID/EX pipeline register
//   IDEX_RESET  - ID/EX contents while reset_n is low
//   make_bubble - turns a loaded record into a bubble
package cpu_pkg;

  localparam int XLEN     = 64;
  localparam int NUM_REGS = 32;
  localparam int CTRL_W   = 16;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [4:0]        rd;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } idex_t;

  localparam idex_t IDEX_RESET = '{
    rd1:      '0,
    rd2:      '0,
    rn:       ZERO_REG,
    rm:       ZERO_REG,
    rd:       ZERO_REG,
    mem_read: 1'b0,
    ctrl:     '0,
    valid:    1'b0
  };

  // A bubble keeps the operand and source-register fields so EX still sees
  // well-defined data, but cannot write anything or trigger a load-use.
  function automatic idex_t make_bubble(input idex_t f);
    idex_t b;
    b          = f;
    b.valid    = 1'b0;
    b.mem_read = 1'b0;
    b.ctrl     = '0;
    b.rd       = ZERO_REG;
    return b;
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x64 register file, X31 hard-wired to zero
//
// Purpose: architectural register storage with one write and two read ports.
// Ports:
//   clk, reset_n     - rising-edge clock, asynchronous active-low clear
//   we, waddr, wdata - write port, committed on the rising edge
//   raddr1, raddr2   - read addresses
//   rdata1, rdata2   - combinational read data (X31 returns 0)
module regfile
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ZERO_REG)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == ZERO_REG) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == ZERO_REG) ? '0 : regs[raddr2];

endmodule

// File: rtl/register_read_stage.sv
// rtl/register_read_stage.sv - ID stage: register read, WB bypass, load-use stall, ID/EX register
//
// Purpose: reads operands for the decoded instruction, forwards a same-cycle
// write-back, detects load-use hazards and latches the ID/EX pipeline register.
// Ports:
//   clk, reset_n                       - clock, asynchronous active-low reset
//   RegWriteWB, WriteRegWB, FinalWriteData - write-back port
//   in_valid, Rn, Rm, Rd, MemReadID, CtrlID - decoded instruction
//   flush                              - taken branch, squash the ID instruction
//   ReadData1EX..ValidEX               - registered ID/EX outputs
//   stall                              - combinational, hold PC and IF/ID
module register_read_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWriteWB,
  input  logic [4:0]        WriteRegWB,
  input  logic [XLEN-1:0]   FinalWriteData,
  input  logic              in_valid,
  input  logic [4:0]        Rn,
  input  logic [4:0]        Rm,
  input  logic [4:0]        Rd,
  input  logic              MemReadID,
  input  logic [CTRL_W-1:0] CtrlID,
  input  logic              flush,
  output logic [XLEN-1:0]   ReadData1EX,
  output logic [XLEN-1:0]   ReadData2EX,
  output logic [4:0]        RnEX,
  output logic [4:0]        RmEX,
  output logic [4:0]        RdEX,
  output logic              MemReadEX,
  output logic [CTRL_W-1:0] CtrlEX,
  output logic              ValidEX,
  output logic              stall
);

  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            byp1;
  logic            byp2;
  logic            load_use;
  idex_t           idex_d;
  idex_t           idex_q;

  regfile u_regfile (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (RegWriteWB),
    .waddr  (WriteRegWB),
    .wdata  (FinalWriteData),
    .raddr1 (Rn),
    .raddr2 (Rm),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // The array only updates at the edge, so a write landing this cycle must be
  // forwarded to a reader of the same register. X31 is never forwarded.
  assign byp1 = RegWriteWB && (WriteRegWB == Rn) && (Rn != ZERO_REG);
  assign byp2 = RegWriteWB && (WriteRegWB == Rm) && (Rm != ZERO_REG);
  assign op1  = byp1 ? FinalWriteData : rf_rd1;
  assign op2  = byp2 ? FinalWriteData : rf_rd2;

  // A bubble in EX has RdEX=31 and ValidEX=0, so a re-presented instruction
  // never matches against it and proceeds on the following cycle.
  assign load_use = ValidEX && MemReadEX && (RdEX != ZERO_REG) && in_valid &&
                    ((RdEX == Rn) || (RdEX == Rm));

  // A flush discards the dependent instruction anyway, so it must not stall.
  assign stall = load_use && !flush;

  always_comb begin
    idex_d          = IDEX_RESET;
    idex_d.rd1      = op1;
    idex_d.rd2      = op2;
    idex_d.rn       = Rn;
    idex_d.rm       = Rm;
    idex_d.rd       = Rd;
    idex_d.mem_read = MemReadID;
    idex_d.ctrl     = CtrlID;
    idex_d.valid    = in_valid;
    if (flush || load_use) begin
      idex_d = make_bubble(idex_d);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_q <= IDEX_RESET;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ReadData1EX = idex_q.rd1;
  assign ReadData2EX = idex_q.rd2;
  assign RnEX        = idex_q.rn;
  assign RmEX        = idex_q.rm;
  assign RdEX        = idex_q.rd;
  assign MemReadEX   = idex_q.mem_read;
  assign CtrlEX      = idex_q.ctrl;
  assign ValidEX     = idex_q.valid;

endmodule

// File: tb/tb_register_read_stage.sv
// tb/tb_register_read_stage.sv - directed self-checking bench for register_read_stage
module tb_register_read_stage;

  logic        clk;
  logic        reset_n;
  logic        RegWriteWB;
  logic [4:0]  WriteRegWB;
  logic [63:0] FinalWriteData;
  logic        in_valid;
  logic [4:0]  Rn;
  logic [4:0]  Rm;
  logic [4:0]  Rd;
  logic        MemReadID;
  logic [15:0] CtrlID;
  logic        flush;
  logic [63:0] ReadData1EX;
  logic [63:0] ReadData2EX;
  logic [4:0]  RnEX;
  logic [4:0]  RmEX;
  logic [4:0]  RdEX;
  logic        MemReadEX;
  logic [15:0] CtrlEX;
  logic        ValidEX;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  register_read_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWriteWB    (RegWriteWB),
    .WriteRegWB    (WriteRegWB),
    .FinalWriteData(FinalWriteData),
    .in_valid      (in_valid),
    .Rn            (Rn),
    .Rm            (Rm),
    .Rd            (Rd),
    .MemReadID     (MemReadID),
    .CtrlID        (CtrlID),
    .flush         (flush),
    .ReadData1EX   (ReadData1EX),
    .ReadData2EX   (ReadData2EX),
    .RnEX          (RnEX),
    .RmEX          (RmEX),
    .RdEX          (RdEX),
    .MemReadEX     (MemReadEX),
    .CtrlEX        (CtrlEX),
    .ValidEX       (ValidEX),
    .stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        iv;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
    logic        mr;
    logic [15:0] ctrl;
    logic        fl;
    logic        e_stall;
    logic [63:0] e_rd1;
    logic [63:0] e_rd2;
    logic [4:0]  e_rn;
    logic [4:0]  e_rm;
    logic [4:0]  e_rd;
    logic        e_mr;
    logic [15:0] e_ctrl;
    logic        e_v;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic iv, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic mr, input logic [15:0] ctrl,
                       input logic fl);
    RegWriteWB = we; WriteRegWB = wa; FinalWriteData = wd;
    in_valid = iv; Rn = rn; Rm = rm; Rd = rd; MemReadID = mr; CtrlID = ctrl; flush = fl;
  endtask

  task automatic check_ex(input string tag, input logic [63:0] rd1, input logic [63:0] rd2,
                          input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                          input logic mr, input logic [15:0] ctrl, input logic v);
    check({tag, ".ReadData1EX"}, ReadData1EX, rd1);
    check({tag, ".ReadData2EX"}, ReadData2EX, rd2);
    check({tag, ".RnEX"}, 64'(RnEX), 64'(rn));
    check({tag, ".RmEX"}, 64'(RmEX), 64'(rm));
    check({tag, ".RdEX"}, 64'(RdEX), 64'(rd));
    check({tag, ".MemReadEX"}, 64'(MemReadEX), 64'(mr));
    check({tag, ".CtrlEX"}, 64'(CtrlEX), 64'(ctrl));
    check({tag, ".ValidEX"}, 64'(ValidEX), 64'(v));
  endtask

  initial begin
    // we wa wd | iv rn rm rd mr ctrl fl | stall | rd1 rd2 rnEX rmEX rdEX mrEX ctrlEX vEX
    // write X5=155 with nothing valid in ID
    vecs[0]  = '{1, 5, 64'd155, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 64'd0, 64'd0, 0, 0, 0, 0, 16'h0000, 0};
    // read X5 written last cycle
    vecs[1]  = '{0, 0, 64'd0, 1, 5, 0, 1, 0, 16'h00A5, 0, 0, 64'd155, 64'd0, 5, 0, 1, 0, 16'h00A5, 1};
    // same-cycle bypass of X7=99 on Rm
    vecs[2]  = '{1, 7, 64'd99, 1, 5, 7, 2, 0, 16'h0001, 0, 0, 64'd155, 64'd99, 5, 7, 2, 0, 16'h0001, 1};
    // write to X31 ignored, not bypassed
    vecs[3]  = '{1, 31, 64'd12, 1, 31, 7, 4, 0, 16'h0002, 0, 0, 64'd0, 64'd99, 31, 7, 4, 0, 16'h0002, 1};
    // X31 still reads 0; X7 stored
    vecs[4]  = '{0, 0, 64'd0, 1, 31, 5, 6, 0, 16'h0003, 0, 0, 64'd0, 64'd155, 31, 5, 6, 0, 16'h0003, 1};
    // load X3
    vecs[5]  = '{0, 0, 64'd0, 1, 5, 7, 3, 1, 16'h0003, 0, 0, 64'd155, 64'd99, 5, 7, 3, 1, 16'h0003, 1};
    // dependent on X3: stall, bubble loaded
    vecs[6]  = '{0, 0, 64'd0, 1, 3, 0, 8, 0, 16'h0004, 0, 1, 64'd0, 64'd0, 3, 0, 31, 0, 16'h0000, 0};
    // re-presented, load data returns via bypass, issues
    vecs[7]  = '{1, 3, 64'h1234, 1, 3, 0, 8, 0, 16'h0004, 0, 0, 64'h1234, 64'd0, 3, 0, 8, 0, 16'h0004, 1};
    // load X9
    vecs[8]  = '{0, 0, 64'd0, 1, 0, 0, 9, 1, 16'h0005, 0, 0, 64'd0, 64'd0, 0, 0, 9, 1, 16'h0005, 1};
    // load-use with flush and write-back of X9
    vecs[9]  = '{1, 9, 64'd777, 1, 3, 9, 10, 0, 16'h0006, 1, 0, 64'h1234, 64'd777, 3, 9, 31, 0, 16'h0000, 0};
    // X9 write committed despite flush
    vecs[10] = '{0, 0, 64'd0, 1, 9, 3, 11, 0, 16'h0007, 0, 0, 64'd777, 64'h1234, 9, 3, 11, 0, 16'h0007, 1};
    // load X12
    vecs[11] = '{0, 0, 64'd0, 1, 9, 9, 12, 1, 16'h0008, 0, 0, 64'd777, 64'd777, 9, 9, 12, 1, 16'h0008, 1};
    // matching regs but in_valid=0: no stall
    vecs[12] = '{0, 0, 64'd0, 0, 12, 12, 13, 0, 16'h0009, 0, 0, 64'd0, 64'd0, 12, 12, 13, 0, 16'h0009, 0};

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_ex("reset", 64'd0, 64'd0, 31, 31, 31, 0, 16'h0, 0);
    check("reset.stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].iv, vecs[i].rn, vecs[i].rm,
            vecs[i].rd, vecs[i].mr, vecs[i].ctrl, vecs[i].fl);
      #1;
      check($sformatf("v%0d.stall", i), 64'(stall), 64'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check_ex($sformatf("v%0d", i), vecs[i].e_rd1, vecs[i].e_rd2, vecs[i].e_rn, vecs[i].e_rm,
               vecs[i].e_rd, vecs[i].e_mr, vecs[i].e_ctrl, vecs[i].e_v);
    end

    // Asynchronous reset in the middle of a stall.
    @(negedge clk);
    drive(0, 0, 0, 1, 9, 3, 20, 1, 16'h00AA, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 1, 20, 0, 21, 0, 16'h00BB, 0);
    #1;
    check("mid.stall_before_reset", 64'(stall), 64'd1);
    check("mid.rd1_before_reset", ReadData1EX, 64'd777);
    #1;
    reset_n = 1'b0;
    #1;
    check_ex("async_reset", 64'd0, 64'd0, 31, 31, 31, 0, 16'h0, 0);
    check("async_reset.stall", 64'(stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    #1;
    check("post_reset.stall", 64'(stall), 64'd0);

    // Every register previously written must read back 0.
    for (int r = 0; r < 32; r += 2) begin
      if (r != 0) @(negedge clk);
      drive(0, 0, 0, 1, 5'(r), 5'(r + 1), 0, 0, 16'h0, 0);
      @(posedge clk);
      #1;
      check($sformatf("post_reset.X%0d", r), ReadData1EX, 64'd0);
      check($sformatf("post_reset.X%0d", r + 1), ReadData2EX, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
